// File: rtl/core_pkg.sv
// Shared ARM core definitions: operand/address widths and the decoded
// control bundle that travels down the pipeline as one unit.
package core_pkg;

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned REG_AW    = 4;
   localparam int unsigned EXE_CMD_W = 4;
   localparam int unsigned STATUS_W  = 4;

   // Decoded control bits; a cleared bundle is a side-effect-free bubble.
   typedef struct packed {
      logic                 wb_en;
      logic                 mem_r_en;
      logic                 mem_w_en;
      logic                 s;
      logic                 b;
      logic                 imm;
      logic [EXE_CMD_W-1:0] exe_cmd;
   } ctrl_t;

endpackage : core_pkg

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register.
// Priority per rising edge: reset > clear > hold > load. Clear and reset
// both drive zero.
module pipe_field_reg #(
   parameter int unsigned W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_hold,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   // Field state update with reset/clear/hold/load priority
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_q <= '0;
      else if (i_clr)
         r_q <= '0;
      else if (!i_hold)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule : pipe_field_reg

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register of the 5-stage ARM core.
// flush inserts a bubble (all fields zero, bubble_out=1); freeze holds
// everything including bubble_out; rst has highest priority.
// Optional macro ID_EX_BUBBLE_CNT_EN adds a saturating 16-bit count of
// accepted flushes on output bubble_cnt.
module id_ex_pipe_reg
   import core_pkg::*;
#(
   parameter int unsigned DATA_W = core_pkg::DATA_W,
   parameter int unsigned REG_AW = core_pkg::REG_AW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 freeze,
   input  logic [DATA_W-1:0]    pc_in,
   input  logic [DATA_W-1:0]    val_rn_in,
   input  logic [DATA_W-1:0]    val_rm_in,
   input  logic [REG_AW-1:0]    src1_in,
   input  logic [REG_AW-1:0]    src2_in,
   input  logic [REG_AW-1:0]    dest_in,
   input  logic [EXE_CMD_W-1:0] exe_cmd_in,
   input  logic [11:0]          shift_operand_in,
   input  logic [23:0]          imm24_in,
   input  logic                 imm_in,
   input  logic                 s_in,
   input  logic                 b_in,
   input  logic                 wb_en_in,
   input  logic                 mem_r_en_in,
   input  logic                 mem_w_en_in,
   input  logic [STATUS_W-1:0]  status_in,
   input  logic                 valid_in,
   output logic [DATA_W-1:0]    pc_out,
   output logic [DATA_W-1:0]    val_rn_out,
   output logic [DATA_W-1:0]    val_rm_out,
   output logic [REG_AW-1:0]    src1_out,
   output logic [REG_AW-1:0]    src2_out,
   output logic [REG_AW-1:0]    dest_out,
   output logic [EXE_CMD_W-1:0] exe_cmd_out,
   output logic [11:0]          shift_operand_out,
   output logic [23:0]          imm24_out,
   output logic                 imm_out,
   output logic                 s_out,
   output logic                 b_out,
   output logic                 wb_en_out,
   output logic                 mem_r_en_out,
   output logic                 mem_w_en_out,
   output logic [STATUS_W-1:0]  status_out,
   output logic                 valid_out,
   output logic                 bubble_out
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [15:0]          bubble_cnt
`endif
);

   localparam int unsigned DATA_BUS_W = 3*DATA_W + 3*REG_AW + 12 + 24 + STATUS_W + 1;

   ctrl_t                 w_ctrl_d;
   ctrl_t                 w_ctrl_q;
   logic [DATA_BUS_W-1:0] w_data_d;
   logic [DATA_BUS_W-1:0] w_data_q;
   logic                  r_bubble;

   assign w_ctrl_d = '{wb_en:    wb_en_in,
                       mem_r_en: mem_r_en_in,
                       mem_w_en: mem_w_en_in,
                       s:        s_in,
                       b:        b_in,
                       imm:      imm_in,
                       exe_cmd:  exe_cmd_in};

   assign w_data_d = {pc_in, val_rn_in, val_rm_in, src1_in, src2_in, dest_in,
                      shift_operand_in, imm24_in, status_in, valid_in};

   pipe_field_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_clr  (flush),
      .i_hold (freeze),
      .i_d    (w_ctrl_d),
      .o_q    (w_ctrl_q)
   );

   pipe_field_reg #(.W(DATA_BUS_W)) u_data_reg (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_clr  (flush),
      .i_hold (freeze),
      .i_d    (w_data_d),
      .o_q    (w_data_q)
   );

   // Bubble marker: set by flush, held by freeze, cleared by any real load
   always_ff @(posedge clk) begin
      if (rst)
         r_bubble <= 1'b0;
      else if (flush)
         r_bubble <= 1'b1;
      else if (!freeze)
         r_bubble <= 1'b0;
   end

   assign wb_en_out    = w_ctrl_q.wb_en;
   assign mem_r_en_out = w_ctrl_q.mem_r_en;
   assign mem_w_en_out = w_ctrl_q.mem_w_en;
   assign s_out        = w_ctrl_q.s;
   assign b_out        = w_ctrl_q.b;
   assign imm_out      = w_ctrl_q.imm;
   assign exe_cmd_out  = w_ctrl_q.exe_cmd;

   assign {pc_out, val_rn_out, val_rm_out, src1_out, src2_out, dest_out,
           shift_operand_out, imm24_out, status_out, valid_out} = w_data_q;

   assign bubble_out = r_bubble;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [15:0] r_bubble_cnt;

   // Saturating count of accepted flushes (flush beats freeze, so counted)
   always_ff @(posedge clk) begin
      if (rst)
         r_bubble_cnt <= '0;
      else if (flush && (r_bubble_cnt != '1))
         r_bubble_cnt <= r_bubble_cnt + 16'd1;
   end

   assign bubble_cnt = r_bubble_cnt;
`else
   // No bubble counter in this build.
`endif

endmodule : id_ex_pipe_reg

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg.
// Covers reset, load latency, freeze hold, flush bubble, flush+freeze
// priority and reset during freeze. Counter checks follow
// ID_EX_BUBBLE_CNT_EN.
module tb_id_ex_pipe_reg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rn;
      logic [31:0] rm;
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic [3:0]  dest;
      logic [3:0]  exe;
      logic [11:0] shift;
      logic [23:0] imm24;
      logic        imm;
      logic        s;
      logic        b;
      logic        wb;
      logic        mr;
      logic        mw;
      logic [3:0]  status;
      logic        valid;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, flush, freeze;
   logic [31:0] pc_in, val_rn_in, val_rm_in;
   logic [3:0]  src1_in, src2_in, dest_in, exe_cmd_in, status_in;
   logic [11:0] shift_operand_in;
   logic [23:0] imm24_in;
   logic        imm_in, s_in, b_in, wb_en_in, mem_r_en_in, mem_w_en_in, valid_in;
   logic [31:0] pc_out, val_rn_out, val_rm_out;
   logic [3:0]  src1_out, src2_out, dest_out, exe_cmd_out, status_out;
   logic [11:0] shift_operand_out;
   logic [23:0] imm24_out;
   logic        imm_out, s_out, b_out, wb_en_out, mem_r_en_out, mem_w_en_out, valid_out;
   logic        bubble_out;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [15:0] bubble_cnt;
`endif

   int n_asrt = 0;
   int n_fail = 0;

   vec_t v_zero, v_ones, v_load, v_a, v_b, v_c, v_d, v_e, v_f;

   always #5 clk = ~clk;

   id_ex_pipe_reg #(.DATA_W(32), .REG_AW(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .flush             (flush),
      .freeze            (freeze),
      .pc_in             (pc_in),
      .val_rn_in         (val_rn_in),
      .val_rm_in         (val_rm_in),
      .src1_in           (src1_in),
      .src2_in           (src2_in),
      .dest_in           (dest_in),
      .exe_cmd_in        (exe_cmd_in),
      .shift_operand_in  (shift_operand_in),
      .imm24_in          (imm24_in),
      .imm_in            (imm_in),
      .s_in              (s_in),
      .b_in              (b_in),
      .wb_en_in          (wb_en_in),
      .mem_r_en_in       (mem_r_en_in),
      .mem_w_en_in       (mem_w_en_in),
      .status_in         (status_in),
      .valid_in          (valid_in),
      .pc_out            (pc_out),
      .val_rn_out        (val_rn_out),
      .val_rm_out        (val_rm_out),
      .src1_out          (src1_out),
      .src2_out          (src2_out),
      .dest_out          (dest_out),
      .exe_cmd_out       (exe_cmd_out),
      .shift_operand_out (shift_operand_out),
      .imm24_out         (imm24_out),
      .imm_out           (imm_out),
      .s_out             (s_out),
      .b_out             (b_out),
      .wb_en_out         (wb_en_out),
      .mem_r_en_out      (mem_r_en_out),
      .mem_w_en_out      (mem_w_en_out),
      .status_out        (status_out),
      .valid_out         (valid_out),
      .bubble_out        (bubble_out)
`ifdef ID_EX_BUBBLE_CNT_EN
      ,
      .bubble_cnt        (bubble_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      pc_in            = v.pc;
      val_rn_in        = v.rn;
      val_rm_in        = v.rm;
      src1_in          = v.src1;
      src2_in          = v.src2;
      dest_in          = v.dest;
      exe_cmd_in       = v.exe;
      shift_operand_in = v.shift;
      imm24_in         = v.imm24;
      imm_in           = v.imm;
      s_in             = v.s;
      b_in             = v.b;
      wb_en_in         = v.wb;
      mem_r_en_in      = v.mr;
      mem_w_en_in      = v.mw;
      status_in        = v.status;
      valid_in         = v.valid;
   endtask

   task automatic expect_all(input string tag, input vec_t v, input logic bub);
      chk({tag, ".pc"},     pc_out,                     v.pc);
      chk({tag, ".rn"},     val_rn_out,                 v.rn);
      chk({tag, ".rm"},     val_rm_out,                 v.rm);
      chk({tag, ".src1"},   {28'd0, src1_out},          {28'd0, v.src1});
      chk({tag, ".src2"},   {28'd0, src2_out},          {28'd0, v.src2});
      chk({tag, ".dest"},   {28'd0, dest_out},          {28'd0, v.dest});
      chk({tag, ".exe"},    {28'd0, exe_cmd_out},       {28'd0, v.exe});
      chk({tag, ".shift"},  {20'd0, shift_operand_out}, {20'd0, v.shift});
      chk({tag, ".imm24"},  {8'd0, imm24_out},          {8'd0, v.imm24});
      chk({tag, ".ctrl"},   {26'd0, imm_out, s_out, b_out, wb_en_out, mem_r_en_out, mem_w_en_out},
                            {26'd0, v.imm, v.s, v.b, v.wb, v.mr, v.mw});
      chk({tag, ".status"}, {28'd0, status_out},        {28'd0, v.status});
      chk({tag, ".valid"},  {31'd0, valid_out},         {31'd0, v.valid});
      chk({tag, ".bubble"}, {31'd0, bubble_out},        {31'd0, bub});
   endtask

   task automatic expect_cnt(input string tag, input logic [15:0] exp);
`ifdef ID_EX_BUBBLE_CNT_EN
      chk({tag, ".cnt"}, {16'd0, bubble_cnt}, {16'd0, exp});
`else
      if (exp == 16'hFFFF) $display("unused %s", tag);
`endif
   endtask

   // Advance one rising edge and settle past it before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      v_zero = '0;
      v_ones = '1;
      v_load = '0;
      v_load.pc = 32'h0000_0010; v_load.src1 = 4'd3; v_load.src2 = 4'd7;
      v_load.dest = 4'd5; v_load.wb = 1'b1;
      v_a = '{pc:32'h100, rn:32'hAAAA5555, rm:32'h12345678, src1:4'd1, src2:4'd2,
              dest:4'd9, exe:4'h2, shift:12'h123, imm24:24'hABCDEF, imm:1'b1, s:1'b1,
              b:1'b0, wb:1'b1, mr:1'b1, mw:1'b0, status:4'hA, valid:1'b1};
      v_b = '{pc:32'h200, rn:32'h0F0F0F0F, rm:32'hDEADBEEF, src1:4'd4, src2:4'd5,
              dest:4'd6, exe:4'h9, shift:12'hFED, imm24:24'h800001, imm:1'b0, s:1'b0,
              b:1'b1, wb:1'b0, mr:1'b0, mw:1'b1, status:4'h5, valid:1'b1};
      v_c = '{pc:32'h304, rn:32'h1, rm:32'h2, src1:4'd8, src2:4'd10, dest:4'd11,
              exe:4'h4, shift:12'h0FF, imm24:24'h000010, imm:1'b0, s:1'b1, b:1'b0,
              wb:1'b0, mr:1'b0, mw:1'b1, status:4'hC, valid:1'b1};
      v_d = '{pc:32'h400, rn:32'h55, rm:32'h66, src1:4'd12, src2:4'd13, dest:4'd14,
              exe:4'h6, shift:12'h800, imm24:24'hFFFFFE, imm:1'b1, s:1'b0, b:1'b0,
              wb:1'b1, mr:1'b0, mw:1'b0, status:4'h3, valid:1'b1};
      v_e = v_a;
      v_e.pc = 32'h500;
      v_f = v_b;
      v_f.pc = 32'h600; v_f.dest = 4'd2;

      // Reset with every input high, including flush and freeze
      rst = 1'b1; flush = 1'b1; freeze = 1'b1;
      apply(v_ones);
      tick();
      expect_all("rst1", v_zero, 1'b0);
      tick();
      expect_all("rst2", v_zero, 1'b0);
      expect_cnt("rst2", 16'd0);

      // Plain load: nothing visible before the edge, all fields after it
      rst = 1'b0; flush = 1'b0; freeze = 1'b0;
      apply(v_load);
      #2;
      chk("load.pre_edge_pc", pc_out, 32'h0);
      tick();
      expect_all("load", v_load, 1'b0);

      // Freeze holds A for three edges while inputs show B
      apply(v_a);
      tick();
      expect_all("loadA", v_a, 1'b0);
      freeze = 1'b1;
      apply(v_b);
      tick();
      expect_all("frz1", v_a, 1'b0);
      tick();
      expect_all("frz2", v_a, 1'b0);
      tick();
      expect_all("frz3", v_a, 1'b0);
      freeze = 1'b0;
      tick();
      expect_all("unfrzB", v_b, 1'b0);

      // Flush after a store: bubble with all fields zero
      apply(v_c);
      tick();
      expect_all("loadC", v_c, 1'b0);
      flush = 1'b1;
      tick();
      expect_all("flush", v_zero, 1'b1);
      expect_cnt("flush", 16'd1);

      // Freeze right after a flush keeps the bubble marker
      flush = 1'b0; freeze = 1'b1;
      apply(v_d);
      tick();
      expect_all("frzbub", v_zero, 1'b1);
      expect_cnt("frzbub", 16'd1);
      freeze = 1'b0;
      tick();
      expect_all("loadD", v_d, 1'b0);

      // Flush and freeze together: flush wins
      flush = 1'b1; freeze = 1'b1;
      apply(v_a);
      tick();
      expect_all("flushfrz", v_zero, 1'b1);
      expect_cnt("flushfrz", 16'd2);

      // Reset while frozen on an instruction with dest 9
      flush = 1'b0; freeze = 1'b0;
      apply(v_e);
      tick();
      expect_all("loadE", v_e, 1'b0);
      freeze = 1'b1;
      apply(v_f);
      tick();
      chk("heldE.dest", {28'd0, dest_out}, 32'd9);
      rst = 1'b1;
      tick();
      expect_all("rstfrz", v_zero, 1'b0);
      expect_cnt("rstfrz", 16'd0);
      rst = 1'b0; freeze = 1'b0;
      tick();
      expect_all("postrst", v_f, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule : tb_id_ex_pipe_reg
